// File: rtl/muldiv_unit_sc.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide,
// fixed XLEN+2 cycle latency with a start/busy/done handshake.
module muldiv_unit_sc #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write
);

  localparam int unsigned PW = 2 * XLEN;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  count;
  logic [2:0]        op;
  logic              sa, sb, b_zero, ovf;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN-1:0]   acc;   // product high half / partial remainder
  logic [XLEN-1:0]   q;     // multiplier (shifts out) / dividend -> quotient

  logic              accept_c;
  logic              sa_c, sb_c, ovf_c;
  logic [XLEN-1:0]   mag_a_c, mag_b_c;
  logic [XLEN:0]     mul_sum_c;
  logic [XLEN:0]     div_shift_c;
  logic [XLEN-1:0]   div_diff_c;
  logic              div_ok_c;
  logic [XLEN-1:0]   acc_nxt_c, q_nxt_c;
  logic [PW-1:0]     prod_c, prod_s_c;
  logic [XLEN-1:0]   quo_s_c, rem_s_c, res_c;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; start only counts in IDLE and DONE
  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        state_nxt = S_CALC;
        accept_c  = 1'b1;
      end
      S_CALC: if (count == CNT_W'(XLEN - 1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: begin
        accept_c  = start;
        state_nxt = start ? S_CALC : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand decode at accept: sign flags, magnitudes, overflow detect
  always_comb begin
    sa_c    = op_a[XLEN-1] && (funct3 == F_MULH || funct3 == F_MULHSU ||
                               funct3 == F_DIV  || funct3 == F_REM);
    sb_c    = op_b[XLEN-1] && (funct3 == F_MULH || funct3 == F_DIV ||
                               funct3 == F_REM);
    mag_a_c = sa_c ? (~op_a + XLEN'(1)) : op_a;
    mag_b_c = sb_c ? (~op_b + XLEN'(1)) : op_b;
    ovf_c   = (op_a == MIN_NEG) && (&op_b) && (funct3 == F_DIV || funct3 == F_REM);
  end

  // One iteration: shift-add for multiply, restoring step for divide
  always_comb begin
    mul_sum_c   = {1'b0, acc} + {1'b0, (q[0] ? mag_b : '0)};
    div_shift_c = {acc, q[XLEN-1]};
    div_diff_c  = div_shift_c[XLEN-1:0] - mag_b;
    div_ok_c    = div_shift_c >= {1'b0, mag_b};
    if (op[2]) begin
      acc_nxt_c = div_ok_c ? div_diff_c : div_shift_c[XLEN-1:0];
      q_nxt_c   = {q[XLEN-2:0], div_ok_c};
    end else begin
      acc_nxt_c = mul_sum_c[XLEN:1];
      q_nxt_c   = {mul_sum_c[0], q[XLEN-1:1]};
    end
  end

  // Sign correction and special cases applied in FIX
  always_comb begin
    prod_c   = {acc, q};
    prod_s_c = (sa ^ sb) ? (~prod_c + PW'(1)) : prod_c;
    quo_s_c  = (sa ^ sb) ? (~q + XLEN'(1)) : q;
    // Divisor zero leaves |op_a| in acc, so the signed remainder is op_a.
    rem_s_c  = sa ? (~acc + XLEN'(1)) : acc;
    res_c    = '0;
    case (op)
      F_MUL:                      res_c = prod_s_c[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  res_c = prod_s_c[PW-1:XLEN];
      F_DIV, F_DIVU:              res_c = b_zero ? '1 : (ovf ? MIN_NEG : quo_s_c);
      F_REM, F_REMU:              res_c = ovf ? '0 : rem_s_c;
      default:                    res_c = '0;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      op        <= '0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      b_zero    <= 1'b0;
      ovf       <= 1'b0;
      mag_b     <= '0;
      acc       <= '0;
      q         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      reg_write <= 1'b0;
      result    <= '0;
      rd_out    <= '0;
    end else begin
      busy      <= (state_nxt == S_CALC) || (state_nxt == S_FIX);
      done      <= 1'b0;
      reg_write <= 1'b0;
      if (accept_c) begin
        op     <= funct3;
        rd_out <= rd_in;
        sa     <= sa_c;
        sb     <= sb_c;
        b_zero <= (op_b == '0);
        ovf    <= ovf_c;
        mag_b  <= mag_b_c;
        acc    <= '0;
        q      <= mag_a_c;
        count  <= '0;
      end else if (state == S_CALC) begin
        acc   <= acc_nxt_c;
        q     <= q_nxt_c;
        count <= count + CNT_W'(1);
      end else if (state == S_FIX) begin
        result    <= res_c;
        done      <= 1'b1;
        reg_write <= (rd_out != 5'd0);
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit_sc.sv
// Directed self-checking bench for muldiv_unit_sc.
module tb_muldiv_unit_sc;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [63:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        busy, done, reg_write;
  logic [63:0] result;
  logic [4:0]  rd_out;

  int vectors = 0;
  int errors  = 0;

  muldiv_unit_sc #(.XLEN(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .busy(busy), .done(done),
    .result(result), .rd_out(rd_out), .reg_write(reg_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op, scramble inputs after accept, and measure latency (0 = timeout)
  task automatic do_op(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, output int lat, output int busy_cnt,
                       output logic [63:0] res, output logic [4:0] rdo, output logic rw);
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0; funct3 = ~f; op_a = ~a; op_b = ~b + 64'd3; rd_in = ~rd;
    lat = 0; busy_cnt = 0; res = '0; rdo = '0; rw = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (done) begin
        lat = n; res = result; rdo = rd_out; rw = reg_write;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    #12;
    vectors++;
    if ({busy, done, reg_write} !== 3'b000 || result !== 64'd0 || rd_out !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b rw=%b result=%h rd=%0d, required all zero",
               busy, done, reg_write, result, rd_out);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_mul();
    int lat, bc; logic [63:0] r; logic [4:0] rdo; logic rw;
    do_op(3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, lat, bc, r, rdo, rw);
    vectors++;
    if (lat !== 66) begin errors++; $display("FAIL mul_latency: got %0d, required 66", lat); end
    vectors++;
    if (bc !== 65) begin errors++; $display("FAIL mul_busy_cycles: got %0d, required 65", bc); end
    vectors++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mul_result: got %h, required FFFFFFFFFFFFFFEB", r); end
    vectors++;
    if (rdo !== 5'd5 || rw !== 1'b1) begin errors++; $display("FAIL mul_rd_rw: rd=%0d rw=%b, required rd=5 rw=1", rdo, rw); end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || reg_write !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_one_cycle: done=%b rw=%b busy=%b, required 0 0 0", done, reg_write, busy);
    end
    vectors++;
    if (result !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL result_hold: got %h", result); end
  endtask

  task automatic test_mulh();
    int lat, bc; logic [63:0] r; logic [4:0] rdo; logic rw;
    do_op(3'b001, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd1, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'h4000_0000_0000_0000 || lat !== 66) begin errors++; $display("FAIL mulh_min: got %h lat %0d, required 4000000000000000 lat 66", r, lat); end
    do_op(3'b011, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd2, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL mulhu_min: got %h, required 4000000000000000", r); end
    do_op(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL mulhsu_neg: got %h, required FFFFFFFFFFFFFFFF", r); end
    do_op(3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mulhu_max: got %h, required FFFFFFFFFFFFFFFE", r); end
  endtask

  task automatic test_div();
    int lat, bc; logic [63:0] r; logic [4:0] rdo; logic rw;
    do_op(3'b100, -64'sd7, 64'd2, 5'd6, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFD || lat !== 66) begin errors++; $display("FAIL div_neg: got %h lat %0d, required FFFFFFFFFFFFFFFD lat 66", r, lat); end
    do_op(3'b110, -64'sd7, 64'd2, 5'd6, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL rem_neg: got %h, required FFFFFFFFFFFFFFFF", r); end
    do_op(3'b101, 64'd100, 64'd7, 5'd7, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'd14) begin errors++; $display("FAIL divu: got %0d, required 14", r); end
    do_op(3'b111, 64'd100, 64'd7, 5'd7, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'd2) begin errors++; $display("FAIL remu: got %0d, required 2", r); end
    do_op(3'b110, 64'd7, -64'sd2, 5'd7, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'd1) begin errors++; $display("FAIL rem_pos_negdiv: got %h, required 1", r); end
  endtask

  task automatic test_special();
    int lat, bc; logic [63:0] r; logic [4:0] rdo; logic rw;
    do_op(3'b100, 64'd42, 64'd0, 5'd8, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF || lat !== 66) begin errors++; $display("FAIL div_by_zero: got %h lat %0d, required all ones lat 66", r, lat); end
    do_op(3'b110, 64'd42, 64'd0, 5'd8, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'd42 || lat !== 66) begin errors++; $display("FAIL rem_by_zero: got %h lat %0d, required 42 lat 66", r, lat); end
    do_op(3'b100, -64'sd5, 64'd0, 5'd8, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL div_neg_by_zero: got %h, required all ones", r); end
    do_op(3'b110, -64'sd5, 64'd0, 5'd8, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFB) begin errors++; $display("FAIL rem_neg_by_zero: got %h, required FFFFFFFFFFFFFFFB", r); end
    do_op(3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'h8000_0000_0000_0000 || lat !== 66) begin errors++; $display("FAIL div_overflow: got %h lat %0d, required 8000000000000000 lat 66", r, lat); end
    do_op(3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, lat, bc, r, rdo, rw);
    vectors++;
    if (r !== 64'd0 || lat !== 66) begin errors++; $display("FAIL rem_overflow: got %h lat %0d, required 0 lat 66", r, lat); end
  endtask

  task automatic test_back_to_back();
    int n1, n2;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b000; op_a = 64'd3; op_b = 64'd5; rd_in = 5'd10;
    @(negedge clk);
    funct3 = 3'b111; op_a = 64'd100; op_b = 64'd7; rd_in = 5'd11;
    n1 = 0; n2 = 0;
    for (int n = 1; n <= 300; n++) begin
      if (done && n1 == 0) begin
        n1 = n;
        vectors++;
        if (result !== 64'd15 || rd_out !== 5'd10) begin
          errors++; $display("FAIL b2b_first: result=%0d rd=%0d, required 15 rd 10", result, rd_out);
        end
      end else if (done && n1 != 0) begin
        n2 = n;
        start = 1'b0;
        vectors++;
        if (result !== 64'd2 || rd_out !== 5'd11) begin
          errors++; $display("FAIL b2b_second: result=%0d rd=%0d, required 2 rd 11", result, rd_out);
        end
        break;
      end
      if (n == 67) begin
        vectors++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_again: busy=%b, required 1", busy); end
      end
      @(negedge clk);
    end
    start = 1'b0;
    vectors++;
    if (n1 !== 66 || n2 !== 132) begin
      errors++; $display("FAIL b2b_timing: done at %0d and %0d, required 66 and 132", n1, n2);
    end
    @(negedge clk);
  endtask

  task automatic test_rd_zero();
    int lat, bc; logic [63:0] r; logic [4:0] rdo; logic rw;
    do_op(3'b000, 64'd2, 64'd3, 5'd0, lat, bc, r, rdo, rw);
    vectors++;
    if (lat !== 66 || rw !== 1'b0 || r !== 64'd6 || rdo !== 5'd0) begin
      errors++; $display("FAIL rd_zero: lat=%0d rw=%b result=%0d rd=%0d, required 66 0 6 0", lat, rw, r, rdo);
    end
  endtask

  task automatic test_reset_midop();
    int lat, bc; int seen; logic [63:0] r; logic [4:0] rdo; logic rw;
    @(negedge clk);
    start = 1'b1; funct3 = 3'b100; op_a = 64'd1000; op_b = 64'd3; rd_in = 5'd12;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 64'd0 || reg_write !== 1'b0) begin
      errors++; $display("FAIL reset_midop: busy=%b done=%b result=%h rw=%b, required all zero",
                         busy, done, result, reg_write);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    vectors++;
    if (seen !== 0) begin errors++; $display("FAIL no_done_after_abort: %0d active cycles, required 0", seen); end
    do_op(3'b100, 64'd1000, 64'd3, 5'd12, lat, bc, r, rdo, rw);
    vectors++;
    if (lat !== 66 || r !== 64'd333 || rdo !== 5'd12 || rw !== 1'b1) begin
      errors++; $display("FAIL after_reset_op: lat=%0d result=%0d rd=%0d rw=%b, required 66 333 12 1", lat, r, rdo, rw);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_back_to_back();
    test_rd_zero();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit_sc.md
Name: muldiv_unit_sc

Overview:
Iterative RV64M multiply/divide execute unit. Consumes the two register-file read operands and the decoded funct3/rd, and produces a 64-bit result with a one-cycle write strobe. The strobe drives the register file's WriteData/RD/RegWrite write port. Latency is fixed at XLEN+2 edges per operation, and the start/busy/done handshake lets the control FSM stall the datapath.

Parameters:
XLEN, 64, operand/result width in bits; must be >= 2.
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
start  input  1  request; sampled only in IDLE or DONE.
funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
op_a  input  XLEN  rs1 operand (multiplicand / dividend).
op_b  input  XLEN  rs2 operand (multiplier / divisor).
rd_in  input  5  destination register index.
busy  output  1  high in CALC and FIX.
done  output  1  one-cycle pulse; result and rd_out valid.
result  output  XLEN  registered result; held until the next FIX.
rd_out  output  5  rd_in latched at accept; held until the next accept.
reg_write  output  1  equals done; high only if rd_out != 0.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; busy=0, done=0, reg_write=0, result=0, rd_out=0; counter and internal registers cleared. Reset mid-operation aborts the operation with no done pulse. First accept is possible at the first edge after reset=1.
- FSM states: IDLE, CALC, FIX, DONE.
  - IDLE: start=1 -> CALC at the accepting edge (edge 0).
  - CALC: at edge 0 latch funct3, rd_in, sign flags sa/sb, |op_a|, |op_b|; count=0. Edges 1..XLEN each perform one iteration, count+1. At edge XLEN (count==XLEN-1 before the edge) -> FIX.
  - FIX: at edge XLEN+1 load result with sign correction and special cases -> DONE.
  - DONE: done=1 for exactly one cycle, during the cycle after edge XLEN+1. At edge XLEN+2: start=1 -> CALC (back-to-back accept); otherwise -> IDLE.
- start in CALC or FIX is ignored. Operand and funct3 changes after edge 0 have no effect.
- Signedness:
  - op_a is signed for MULH, MULHSU, DIV, REM.
  - op_b is signed for MULH, DIV, REM.
  - MUL uses the unsigned low half; it is identical for signed operands.
  - The magnitude of -2^(XLEN-1) is 2^(XLEN-1) as unsigned.
- Multiply: shift-add over magnitudes into a 2*XLEN product. If the result is negative (sa^sb), negate the full 2*XLEN product in FIX. MUL returns bits [XLEN-1:0]; MULH/MULHSU/MULHU return [2XLEN-1:XLEN].
- Divide: restoring, 1 quotient bit per iteration over magnitudes. Quotient sign = sa^sb; remainder sign = sa.
- Special cases, resolved in FIX with unchanged latency:
  - Divisor=0: DIV/DIVU -> all ones; REM/REMU -> op_a.
  - Signed overflow (op_a=-2^(XLEN-1), op_b=-1): DIV -> op_a; REM -> 0.
- Total latency: done asserted XLEN+2 cycles after the start-sampling edge, i.e. 66 for XLEN=64. Throughput is one op per XLEN+2 cycles with back-to-back start.

Test Plan:
- Reset, then start MUL op_a=7, op_b=-3 (0xFFFF_FFFF_FFFF_FFFD), rd_in=5 -> busy=1 for 65 cycles; done=reg_write=1 exactly one cycle at 66 cycles; result=0xFFFF_FFFF_FFFF_FFEB, rd_out=5.
- MULH op_a=op_b=0x8000_0000_0000_0000 -> result=0x4000_0000_0000_0000; MULHU same operands -> 0x4000_0000_0000_0000; MULHSU op_a=-1, op_b=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV -7/2 -> result=-3; REM -7/2 -> -1; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Divide by zero: DIV 42/0 -> 0xFFFF_FFFF_FFFF_FFFF; REM 42/0 -> 42. Overflow: DIV 0x8000_0000_0000_0000/-1 -> 0x8000_0000_0000_0000; REM -> 0. Latency stays 66 in all cases.
- Handshake: start held high throughout, with operands changed mid-op -> first result is unaffected and the second op is accepted in the DONE cycle. rd_in=0 -> done=1 but reg_write=0.
- reset pulled low at cycle 30 of a DIV -> busy, done and result are 0 immediately, and no done pulse follows. A new start after release completes normally in 66 cycles.
